// File: rtl/fifo_in_unpack.sv
// Frame-read controller: launches one ram_r frame read, drains its show-ahead FIFO
// and unpacks each word into a valid/ready pixel stream with sof/eol/eof markers.
module fifo_in_unpack #(
    parameter int DATA_WIDTH        = 32,
    parameter int ADD_WIDTH         = 32,
    parameter int PIXEL_WIDTH       = 8,
    parameter int MAX_BURST_COUNT_R = 32,
    parameter int IMG_WIDTH         = 640,
    parameter int IMG_HEIGHT        = 480
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   frame_start,
    input  logic [ADD_WIDTH-1:0]   frame_base,
    output logic                   frame_busy,
    output logic                   frame_done,
    output logic                   start_fifo_in,
    output logic [ADD_WIDTH-1:0]   address_fifo_in,
    output logic [DATA_WIDTH-1:0]  n_burst_fifo_in,
    input  logic [DATA_WIDTH-1:0]  data_fifo_in,
    input  logic                   empty_fifo_in,
    output logic                   read_fifo_in,
    output logic [PIXEL_WIDTH-1:0] pix_data,
    output logic                   pix_valid,
    input  logic                   pix_ready,
    output logic                   pix_sof,
    output logic                   pix_eol,
    output logic                   pix_eof
);

    // state  | meaning
    // IDLE   | waiting for frame_start
    // LAUNCH | one-cycle start_fifo_in pulse to ram_r
    // STREAM | popping words and emitting pixels until the eof pixel is accepted

    localparam int PPW         = DATA_WIDTH / PIXEL_WIDTH;
    localparam int FRAME_WORDS = IMG_WIDTH * IMG_HEIGHT / PPW;
    localparam int N_BURST     = FRAME_WORDS / MAX_BURST_COUNT_R;
    localparam int LANE_W      = (PPW > 1) ? $clog2(PPW) : 1;
    localparam int COL_W       = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int ROW_W       = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int WL_W        = $clog2(FRAME_WORDS + 1);

    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PPW - 1);
    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [WL_W-1:0]   ALL_WORDS = WL_W'(FRAME_WORDS);

    typedef enum logic [1:0] {IDLE, LAUNCH, STREAM} state_t;

    state_t                state, state_next;
    logic [DATA_WIDTH-1:0] word;
    logic                  word_valid;
    logic [LANE_W-1:0]     lane;
    logic [COL_W-1:0]      col;
    logic [ROW_W-1:0]      row;
    logic [WL_W-1:0]       words_left;
    logic                  accept;
    logic                  last_lane;
    logic                  eof_accept;

    assign n_burst_fifo_in = DATA_WIDTH'(N_BURST);
    assign frame_busy      = (state != IDLE);
    assign start_fifo_in   = (state == LAUNCH);

    assign pix_valid  = word_valid;
    assign pix_data   = word[lane*PIXEL_WIDTH +: PIXEL_WIDTH];
    assign pix_sof    = word_valid && (col == '0) && (row == '0);
    assign pix_eol    = word_valid && (col == LAST_COL);
    assign pix_eof    = pix_eol && (row == LAST_ROW);

    assign accept     = word_valid && pix_ready;
    assign last_lane  = (lane == LAST_LANE);
    assign eof_accept = accept && pix_eof;

    // The refill pop overlaps the last-lane accept so words stream without a bubble.
    assign read_fifo_in = (state == STREAM) && !empty_fifo_in &&
                          (!word_valid || (accept && last_lane)) &&
                          (words_left != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (frame_start) state_next = LAUNCH;
            LAUNCH:  state_next = STREAM;
            STREAM:  if (eof_accept) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            address_fifo_in <= '0;
            word            <= '0;
            word_valid      <= 1'b0;
            lane            <= '0;
            col             <= '0;
            row             <= '0;
            words_left      <= '0;
            frame_done      <= 1'b0;
        end else begin
            frame_done <= eof_accept;
            if (state == IDLE) begin
                if (frame_start) begin
                    address_fifo_in <= frame_base;
                    word_valid      <= 1'b0;
                    lane            <= '0;
                    col             <= '0;
                    row             <= '0;
                    words_left      <= ALL_WORDS;
                end
            end else if (state == STREAM) begin
                if (read_fifo_in) begin
                    word       <= data_fifo_in;
                    word_valid <= 1'b1;
                    lane       <= '0;
                    words_left <= words_left - 1'b1;
                end else if (accept) begin
                    lane <= lane + 1'b1;
                    if (last_lane) word_valid <= 1'b0;
                end
                if (accept) begin
                    if (col == LAST_COL) begin
                        col <= '0;
                        row <= (row == LAST_ROW) ? '0 : row + 1'b1;
                    end else begin
                        col <= col + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_in_unpack.sv
// Bench for fifo_in_unpack: a show-ahead FIFO model feeds frames, a scoreboard
// checks every accepted pixel, and a vector table drives the frame scenarios.
module tb_fifo_in_unpack;

    logic        clk;
    logic        rst;
    logic        frame_start;
    logic [31:0] frame_base;
    logic        frame_busy;
    logic        frame_done;
    logic        start_fifo_in;
    logic [31:0] address_fifo_in;
    logic [31:0] n_burst_fifo_in;
    logic [31:0] data_fifo_in;
    logic        empty_fifo_in;
    logic        read_fifo_in;
    logic [7:0]  pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        pix_sof;
    logic        pix_eol;
    logic        pix_eof;

    fifo_in_unpack #(
        .DATA_WIDTH(32), .ADD_WIDTH(32), .PIXEL_WIDTH(8),
        .MAX_BURST_COUNT_R(4), .IMG_WIDTH(8), .IMG_HEIGHT(4)
    ) dut (
        .clk(clk), .rst(rst),
        .frame_start(frame_start), .frame_base(frame_base),
        .frame_busy(frame_busy), .frame_done(frame_done),
        .start_fifo_in(start_fifo_in), .address_fifo_in(address_fifo_in),
        .n_burst_fifo_in(n_burst_fifo_in), .data_fifo_in(data_fifo_in),
        .empty_fifo_in(empty_fifo_in), .read_fifo_in(read_fifo_in),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_eof(pix_eof)
    );

    typedef struct {
        logic [31:0] base;
        bit          ready_rand;
        int          gap_max;
        bit          preload;
        int          n_words;
        bit          mid_start;
        int          abort_at;
        int          exp_pops;
        int          exp_pix;
        bit          consec;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        bit         sof;
        bit         eol;
        bit         eof;
    } pix_t;

    localparam int FRAME_WORDS = 8;
    localparam int FRAME_PIX   = 32;
    localparam int W           = 8;

    pix_t        exp_q[$];
    logic [31:0] fifo[$];
    vec_t        vecs[6];

    int src_total, src_idx, gap_cnt, gap_max;
    bit preload, ready_rand;
    bit pop_pending, start_pending, eof_prev;
    int pops, dones, starts, accepted, cyc, first_acc, last_acc;
    int checks, failures;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input int w);
        return {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)};
    endfunction

    // Pixel p of the frame has value p; position follows from the image width.
    task automatic push_word();
        pix_t e;
        fifo.push_back(word_of(src_idx));
        if (src_idx < FRAME_WORDS) begin
            for (int l = 0; l < 4; l++) begin
                int p;
                p = 4*src_idx + l;
                e.data = 8'(p);
                e.sof  = (p == 0);
                e.eol  = ((p % W) == W-1);
                e.eof  = (p == FRAME_PIX-1);
                exp_q.push_back(e);
            end
        end
        src_idx++;
    endtask

    // FIFO model and downstream driver, applied just after each rising edge.
    initial begin
        logic [31:0] d;
        forever begin
            @(posedge clk);
            #1;
            if (start_pending) begin
                fifo.delete();
                exp_q.delete();
                src_idx = 0;
                gap_cnt = 0;
                if (preload) while (src_idx < src_total) push_word();
            end else begin
                if (pop_pending && fifo.size() > 0) d = fifo.pop_front();
                if (src_idx < src_total) begin
                    if (gap_cnt == 0) begin
                        push_word();
                        gap_cnt = $urandom_range(0, gap_max);
                    end else begin
                        gap_cnt--;
                    end
                end
            end
            data_fifo_in  = (fifo.size() > 0) ? fifo[0] : 32'h0;
            empty_fifo_in = (fifo.size() == 0);
            pix_ready     = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            cyc++;
        end
    end

    // Monitor: samples on the falling edge what the next rising edge will act on.
    initial begin
        pix_t e;
        forever begin
            @(negedge clk);
            pop_pending   = read_fifo_in;
            start_pending = start_fifo_in;
            if (start_fifo_in) starts++;
            if (read_fifo_in) begin
                pops++;
                chk("pop_while_empty", 32'(empty_fifo_in), 32'd0);
            end
            if (frame_done) begin
                dones++;
                chk("done_after_eof", 32'(eof_prev), 32'd1);
                chk("idle_at_done", 32'(frame_busy), 32'd0);
            end
            eof_prev = 1'b0;
            if (pix_valid && pix_ready) begin
                accepted++;
                if (accepted == 1) first_acc = cyc;
                last_acc = cyc;
                eof_prev = pix_eof;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pixel actual=0x%0h required=none", pix_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("pix_data", 32'(pix_data), 32'(e.data));
                    chk("markers_sof_eol_eof", 32'({pix_sof, pix_eol, pix_eof}),
                        32'({e.sof, e.eol, e.eof}));
                end
            end
        end
    end

    task automatic run_frame(input vec_t v);
        bit pulsed;
        pulsed     = 1'b0;
        src_total  = v.n_words;
        gap_max    = v.gap_max;
        preload    = v.preload;
        ready_rand = v.ready_rand;
        pops = 0; dones = 0; starts = 0; accepted = 0; eof_prev = 1'b0;

        @(posedge clk); #2;
        frame_base  = v.base;
        frame_start = 1'b1;
        @(posedge clk); #2;
        frame_start = 1'b0;
        frame_base  = 32'hDEAD_0000;
        @(negedge clk);
        chk("launch_pulse", 32'(start_fifo_in), 32'd1);
        chk("address_latched", address_fifo_in, v.base);
        chk("n_burst", n_burst_fifo_in, 32'd2);
        chk("busy_in_launch", 32'(frame_busy), 32'd1);
        @(negedge clk);
        chk("launch_one_cycle", 32'(start_fifo_in), 32'd0);

        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (frame_start) frame_start = 1'b0;
            if (v.mid_start && !pulsed && accepted >= 10) begin
                frame_start = 1'b1;
                frame_base  = 32'h0BAD_0000;
                pulsed      = 1'b1;
            end
            if (v.abort_at > 0 && accepted >= v.abort_at) break;
            if (dones > 0) break;
        end
        @(negedge clk);
        frame_start = 1'b0;

        if (v.abort_at > 0) begin
            chk("abort_point_reached", 32'(accepted >= v.abort_at), 32'd1);
            @(posedge clk); #2;
            rst       = 1'b0;
            src_total = 0;
            #1;
            chk("rst_pix_valid", 32'(pix_valid), 32'd0);
            chk("rst_busy", 32'(frame_busy), 32'd0);
            chk("rst_start", 32'(start_fifo_in), 32'd0);
            chk("rst_read", 32'(read_fifo_in), 32'd0);
            repeat (3) @(negedge clk);
            chk("no_start_from_rst", 32'(starts), 32'd1);
            @(posedge clk); #2;
            rst = 1'b1;
        end else begin
            chk("frame_done_seen", 32'(dones > 0), 32'd1);
            repeat (10) @(negedge clk);
            chk("pop_count", 32'(pops), 32'(v.exp_pops));
            chk("done_count", 32'(dones), 32'd1);
            chk("start_count", 32'(starts), 32'd1);
            chk("pixel_count", 32'(accepted), 32'(v.exp_pix));
            chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
            chk("idle_after_frame", 32'(frame_busy), 32'd0);
            if (v.consec) chk("no_bubble_span", 32'(last_acc - first_acc), 32'(FRAME_PIX-1));
        end
    endtask

    initial begin
        checks = 0; failures = 0; cyc = 0;
        src_total = 0; src_idx = 0; gap_cnt = 0; gap_max = 0;
        preload = 1'b0; ready_rand = 1'b0;
        pop_pending = 1'b0; start_pending = 1'b0; eof_prev = 1'b0;
        rst = 1'b0; frame_start = 1'b0; frame_base = 32'h0;
        pix_ready = 1'b0; data_fifo_in = 32'h0; empty_fifo_in = 1'b1;

        //          base        rand  gap pre  n  mid abort pops pix consec
        vecs[0] = '{32'h1000, 1'b0, 0, 1'b1, 8, 1'b0, 0,  8, 32, 1'b1};
        vecs[1] = '{32'h2000, 1'b1, 5, 1'b0, 8, 1'b0, 0,  8, 32, 1'b0};
        vecs[2] = '{32'h3000, 1'b1, 0, 1'b0, 8, 1'b1, 0,  8, 32, 1'b0};
        vecs[3] = '{32'h4000, 1'b0, 2, 1'b0, 8, 1'b0, 13, 8, 32, 1'b0};
        vecs[4] = '{32'h5000, 1'b1, 3, 1'b0, 8, 1'b0, 0,  8, 32, 1'b0};
        vecs[5] = '{32'h6000, 1'b0, 0, 1'b1, 9, 1'b0, 0,  8, 32, 1'b1};

        repeat (3) @(negedge clk);
        chk("reset_busy_done_start", 32'({frame_busy, frame_done, start_fifo_in}), 32'd0);
        chk("reset_address", address_fifo_in, 32'd0);
        chk("reset_read", 32'(read_fifo_in), 32'd0);
        chk("reset_pix", 32'({pix_valid, pix_sof, pix_eol, pix_eof, pix_data}), 32'd0);
        chk("reset_n_burst", n_burst_fifo_in, 32'd2);
        @(posedge clk); #2;
        rst = 1'b1;

        for (int i = 0; i < 6; i++) run_frame(vecs[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_in_unpack.md
# fifo_in_unpack

Frame-read controller and pixel unpacker that sits directly downstream of the `ram_r` read master. It launches one frame read with a single-cycle `start_fifo_in` pulse and drains `ram_r`'s show-ahead FIFO one word at a time. Each word is split into packed pixels and emitted as a valid/ready stream with frame and line markers. That stream feeds the Sobel window stage.

## Interface
Parameters:
- DATA_WIDTH, 32: FIFO word width. Must be a multiple of PIXEL_WIDTH.
- ADD_WIDTH, 32: byte address width.
- PIXEL_WIDTH, 8: bits per pixel. PPW = DATA_WIDTH/PIXEL_WIDTH pixels per word (4 with defaults).
- MAX_BURST_COUNT_R, 32: words per burst. Must equal the value configured in `ram_r`.
- IMG_WIDTH, 640: pixels per line. Must be a multiple of PPW.
- IMG_HEIGHT, 480: lines per frame.
- Frame constraint: the frame word count IMG_WIDTH*IMG_HEIGHT/PPW must be a multiple of MAX_BURST_COUNT_R.

Ports:
- clk, in, 1: single clock for all logic.
- rst, in, 1: asynchronous, active-low reset.
- frame_start, in, 1: single-cycle request to read one frame. Sampled only in IDLE.
- frame_base, in, ADD_WIDTH: frame byte base address. Sampled together with frame_start.
- frame_busy, out, 1: high whenever the state is not IDLE.
- frame_done, out, 1: one-cycle pulse after the last pixel is accepted.
- start_fifo_in, out, 1: to `ram_r`; clears its FIFO and loads the read job.
- address_fifo_in, out, ADD_WIDTH: latched frame_base.
- n_burst_fifo_in, out, DATA_WIDTH: constant burst count, IMG_WIDTH*IMG_HEIGHT/(PPW*MAX_BURST_COUNT_R).
- data_fifo_in, in, DATA_WIDTH: show-ahead FIFO head word.
- empty_fifo_in, in, 1: FIFO empty flag.
- read_fifo_in, out, 1: FIFO pop.
- pix_data, out, PIXEL_WIDTH: output pixel.
- pix_valid, out, 1: output pixel is valid.
- pix_ready, in, 1: downstream accepts the pixel.
- pix_sof, out, 1: qualifies the first pixel of the frame.
- pix_eol, out, 1: qualifies the last pixel of each line.
- pix_eof, out, 1: qualifies the last pixel of the frame.

## Operation
- State machine: IDLE -> LAUNCH -> STREAM -> IDLE.
- IDLE:
  - frame_start=1 latches frame_base into address_fifo_in, clears all counters and moves to LAUNCH.
  - frame_start is ignored in every other state.
- LAUNCH: lasts exactly one cycle with start_fifo_in=1, then moves to STREAM.
- STREAM, word register:
  - A holding register `word` is paired with a `word_valid` flag and a lane counter (0..PPW-1).
  - read_fifo_in = STREAM & !empty_fifo_in & (!word_valid | (pix_valid & pix_ready & lane==PPW-1)) & words_left!=0.
  - On a pop, `word` <= data_fifo_in, `word_valid` <= 1, lane <= 0, and words_left decrements.
- STREAM, pixel output:
  - pix_data = word[lane*PIXEL_WIDTH +: PIXEL_WIDTH]. Lane 0 is the least significant byte and is emitted first.
  - pix_valid = word_valid.
  - Each accept (pix_valid & pix_ready) advances lane. After the last lane, word_valid clears unless a pop happens in the same cycle.
- Position counters:
  - col runs 0..IMG_WIDTH-1 and wraps to 0 on each line end, which also increments row (0..IMG_HEIGHT-1).
  - pix_sof = word_valid & col==0 & row==0.
  - pix_eol = word_valid & col==IMG_WIDTH-1.
  - pix_eof = pix_eol & row==IMG_HEIGHT-1.
- Completion: accepting the pix_eof pixel pulses frame_done for the next cycle and returns to IDLE with word_valid=0.
- Reset values: every output is 0 (address_fifo_in=0; n_burst_fifo_in is the constant) and the state is IDLE.
- Reset mid-frame:
  - The immediate async clear drops pix_valid and frame_busy.
  - No start_fifo_in is issued by the reset itself; the next frame's LAUNCH clears the FIFO.

## Timing
- frame_start sampled at edge 0:
  - LAUNCH (start_fifo_in=1) in cycle 1.
  - STREAM from cycle 2.
  - The earliest pop is in cycle 2, if the FIFO is non-empty.
- Pop-to-pixel latency: one cycle. pix_valid rises in the cycle after read_fifo_in.
- Sustained rate: one pixel per cycle with pix_ready=1 and the FIFO non-empty. The pop is overlapped with the last-lane accept, so there is no bubble between words.
- pix_ready=0 holds pix_data and all markers stable; no pop occurs while a word is held unless the last lane is being accepted.
- An empty FIFO never produces a pop.
- Exactly IMG_WIDTH*IMG_HEIGHT/PPW pops occur per frame. words_left blocks any extra pop, even if the FIFO is non-empty.

## Test plan
All scenarios use test parameters IMG_WIDTH=8, IMG_HEIGHT=4, MAX_BURST_COUNT_R=4, PPW=4, so n_burst_fifo_in=2 and the frame is 8 words.
1. Reset with rst=0 -> all outputs 0 and frame_busy=0. Release, then frame_start with frame_base=0x1000 -> start_fifo_in high only in cycle 1, address_fifo_in=0x1000, n_burst_fifo_in=2.
2. FIFO preloaded with words 0x03020100..0x1F1E1D1C and pix_ready=1 -> pix_data 0x00..0x1F on 32 consecutive cycles. pix_sof on 0x00, pix_eol on 0x07/0x0F/0x17/0x1F, pix_eof on 0x1F, frame_done on the next cycle, then IDLE.
3. Random pix_ready toggling, with the FIFO word arrival rate varying from back-to-back to gaps of 5 cycles -> identical pixel sequence and markers, read_fifo_in never asserted while empty_fifo_in=1, exactly 8 pops.
4. frame_start pulsed again mid-frame -> ignored: no second start_fifo_in and the sequence is unaffected.
5. rst asserted after 13 pixels accepted -> outputs clear immediately. A new frame_start then yields a fresh start_fifo_in and pix_sof on the first pixel.
6. Extra 9th word present in the FIFO at frame end -> not popped, and frame_done still pulses once.
